mvm_axis_cmd_tx: RTL

- AXI-Stream initiator that feeds the rx port of rtl_mvm.
- Accepts MVM commands from a valid/ready command port, buffers them in a small FIFO and serialises each into one single-beat AXIS packet.
- Four command types: RF weight write, input vector load, reduction vector load, instruction load. Each is encoded into tuser/tdata exactly as rtl_mvm decodes it.
- Sits between host/NoC command logic and the MVM.

---
 rtl/mvm_axis_pkg.sv | 38 +++
 rtl/mvm_axis_cmd_tx_if.sv | 30 +++
 rtl/mvm_tx_fifo.sv | 41 ++++
 rtl/mvm_axis_cmd_tx.sv | 117 +++++++++++
 4 files changed

// File: rtl/mvm_axis_pkg.sv
// Shared encodings for the MVM AXIS command path: op codes, tuser field layout
// and instruction word bit positions as rtl_mvm decodes them.
package mvm_axis_pkg;

  localparam int TUSER_ADDRW = 9;
  localparam int TUSER_OPW   = 2;
  localparam int TUSER_MASKW = 64;

  localparam int ADDR_LSB = 0;
  localparam int OP_LSB   = ADDR_LSB + TUSER_ADDRW;
  localparam int MASK_LSB = OP_LSB + TUSER_OPW;
  localparam int TUSER_W  = MASK_LSB + TUSER_MASKW;

  typedef enum logic [TUSER_OPW-1:0] {
    OP_INST = 2'b00,
    OP_RVEC = 2'b01,
    OP_IVEC = 2'b10,
    OP_RFW  = 2'b11
  } mvm_op_e;

  localparam int INST_RDC            = 0;
  localparam int INST_ACM            = 1;
  localparam int INST_RLS            = 2;
  localparam int INST_LST            = 3;
  localparam int INST_ACCUM_ADDR_LSB = 4;
  localparam int INST_ACCUM_ADDR_MSB = 12;
  localparam int INST_RF_ADDR_LSB    = 13;
  localparam int INST_RF_ADDR_MSB    = 21;
  localparam int INST_RLS_DEST_LSB   = 22;
  localparam int INST_RLS_DEST_MSB   = 30;
  localparam int INST_RLS_OP         = 31;

  // Only RF writes carry a meaningful address and lane mask.
  function automatic logic is_rf_write(input logic [TUSER_OPW-1:0] op);
    return op == OP_RFW;
  endfunction

endpackage

// File: rtl/mvm_axis_cmd_tx_if.sv
// AXI-Stream bus carrying single-beat MVM command packets.
interface mvm_axis_cmd_tx_if
  import mvm_axis_pkg::*;
#(
  parameter int DATAW = 512,
  parameter int BYTEW = 8,
  parameter int IDW   = 32,
  parameter int DESTW = 12,
  parameter int USERW = TUSER_W
);
  logic             tvalid;
  logic             tready;
  logic [DATAW-1:0] tdata;
  logic [BYTEW-1:0] tstrb;
  logic [BYTEW-1:0] tkeep;
  logic [IDW-1:0]   tid;
  logic [DESTW-1:0] tdest;
  logic [USERW-1:0] tuser;
  logic             tlast;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/mvm_tx_fifo.sv
// Synchronous FIFO of packed command entries; head is visible combinationally
// so the downstream register stage acts as the registered read.
module mvm_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   occupancy
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Pointers carry one extra wrap bit, so occupancy reaches DEPTH exactly when full.
  assign occupancy = wr_ptr_reg - rd_ptr_reg;
  assign full      = occupancy[AW];
  assign empty     = (occupancy == '0);
  assign rdata     = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/mvm_axis_cmd_tx.sv
// Command-to-AXIS initiator for rtl_mvm: queues commands and emits each as one
// single-beat packet with the op/addr/mask encoded into tuser.
module mvm_axis_cmd_tx
  import mvm_axis_pkg::*;
#(
  parameter int DATAW     = 512,
  parameter int BYTEW     = 8,
  parameter int IDW       = 32,
  parameter int DESTW     = 12,
  parameter int USERW     = 75,
  parameter int RFADDRW   = 9,
  parameter int AXIS_OPSW = 2,
  parameter int MASKW     = 64,
  parameter int FIFOD     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AXIS_OPSW-1:0] cmd_op,
  input  logic [RFADDRW-1:0]   cmd_addr,
  input  logic [MASKW-1:0]     cmd_mask,
  input  logic [DESTW-1:0]     cmd_dest,
  input  logic [DATAW-1:0]     cmd_data,
  mvm_axis_cmd_tx_if.master    axis_tx,
  output logic [31:0]          tx_count,
  output logic                 busy
);
  localparam int ENTRYW = DESTW + USERW + DATAW;
  localparam int OCCW   = $clog2(FIFOD) + 1;

  logic              is_rfw;
  logic [USERW-1:0]  cmd_tuser;
  logic [ENTRYW-1:0] cmd_entry;
  logic [ENTRYW-1:0] fifo_head;
  logic [ENTRYW-1:0] stage_src;
  logic [OCCW-1:0]   occupancy;
  logic              fifo_full, fifo_empty;
  logic              push, fifo_push, fifo_pop, bypass, stage_free, xfer;

  logic              tvalid_reg;
  logic              tlast_reg;
  logic [DATAW-1:0]  tdata_reg;
  logic [USERW-1:0]  tuser_reg;
  logic [DESTW-1:0]  tdest_reg;
  logic [IDW-1:0]    tid_reg;
  logic [31:0]       tx_count_reg;

  assign is_rfw    = is_rf_write(cmd_op);
  assign cmd_tuser = {cmd_mask & {MASKW{is_rfw}}, cmd_op, cmd_addr & {RFADDRW{is_rfw}}};
  assign cmd_entry = {cmd_dest, cmd_tuser, cmd_data};

  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign xfer       = tvalid_reg && axis_tx.tready;
  assign stage_free = !tvalid_reg || axis_tx.tready;
  assign fifo_pop   = stage_free && !fifo_empty;
  // An empty queue lets a new command skip straight into the output stage,
  // giving one-cycle accept-to-valid latency and full streaming throughput.
  assign bypass     = stage_free && fifo_empty && push;
  assign fifo_push  = push && !bypass;
  assign stage_src  = fifo_empty ? cmd_entry : fifo_head;

  mvm_tx_fifo #(
    .W     (ENTRYW),
    .DEPTH (FIFOD)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .wdata     (cmd_entry),
    .pop       (fifo_pop),
    .rdata     (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tdata_reg  <= '0;
      tuser_reg  <= '0;
      tdest_reg  <= '0;
    end else if (stage_free) begin
      tvalid_reg <= fifo_pop || bypass;
      if (fifo_pop || bypass) begin
        {tdest_reg, tuser_reg, tdata_reg} <= stage_src;
        tlast_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tid_reg      <= '0;
      tx_count_reg <= '0;
    end else if (xfer) begin
      tid_reg <= tid_reg + 1'b1;
      if (tx_count_reg != '1) tx_count_reg <= tx_count_reg + 32'd1;
    end
  end

  // Strobes track tlast: zero out of reset, all-ones once any beat is loaded.
  assign axis_tx.tvalid = tvalid_reg;
  assign axis_tx.tdata  = tdata_reg;
  assign axis_tx.tstrb  = {BYTEW{tlast_reg}};
  assign axis_tx.tkeep  = {BYTEW{tlast_reg}};
  assign axis_tx.tid    = tid_reg;
  assign axis_tx.tdest  = tdest_reg;
  assign axis_tx.tuser  = tuser_reg;
  assign axis_tx.tlast  = tlast_reg;

  assign tx_count = tx_count_reg;
  assign busy     = (occupancy != '0) || tvalid_reg;
endmodule
